// File: rtl/dmem_port_arbiter_if.sv
// rtl/dmem_port_arbiter_if.sv - bus bundle between CPU MEM stage, secondary master, arbiter and data memory
//
// Purpose: groups every handshake/bus signal of the data-memory port arbiter.
// Modports:
//   master - the requesters and the memory: drive cpu_*/dev_* requests and
//            mem_rdata, observe grants, stall and read returns.
//   slave  - the arbiter: observes requests and mem_rdata, drives grants,
//            stall, read returns and the mem_* port.
// Signal summary:
//   cpu_req/cpu_we/cpu_addr/cpu_wdata/cpu_op  CPU MEM stage access
//   cpu_rdata, cpu_stall                      load data / CPU denied this cycle
//   dev_req/dev_we/dev_addr/dev_wdata/dev_op  device access, held until dev_gnt
//   dev_gnt, dev_rvalid, dev_rdata            device grant and read return
//   mem_addr/mem_wdata/mem_op/mem_we          physical memory port
//   mem_rdata                                 memory data, one cycle after address

interface dmem_port_arbiter_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [2:0]  cpu_op;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;

  logic        dev_req;
  logic        dev_we;
  logic [31:0] dev_addr;
  logic [31:0] dev_wdata;
  logic [2:0]  dev_op;
  logic        dev_gnt;
  logic        dev_rvalid;
  logic [31:0] dev_rdata;

  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [2:0]  mem_op;
  logic        mem_we;
  logic [31:0] mem_rdata;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_op,
    input  cpu_rdata, cpu_stall,
    output dev_req, dev_we, dev_addr, dev_wdata, dev_op,
    input  dev_gnt, dev_rvalid, dev_rdata,
    input  mem_addr, mem_wdata, mem_op, mem_we,
    output mem_rdata
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_op,
    output cpu_rdata, cpu_stall,
    input  dev_req, dev_we, dev_addr, dev_wdata, dev_op,
    output dev_gnt, dev_rvalid, dev_rdata,
    output mem_addr, mem_wdata, mem_op, mem_we,
    input  mem_rdata
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - shares the data-memory port between the CPU MEM stage and a secondary master
//
// Purpose: CPU has default priority; a starvation counter forces a device slot
// after STARVE_MAX consecutive denied device cycles. When the CPU loses a slot
// cpu_stall is raised so the pipeline holds. Read data returns one cycle after
// the grant and is steered back to whichever side issued the read.
// Ports:
//   clk  - system clock, all state on posedge
//   clr  - asynchronous active-low reset
//   bus  - dmem_port_arbiter_if.slave (requests, grants, read returns, mem port)
// Parameters:
//   STARVE_MAX - denied device cycles before a forced grant (0: device always wins)
//   CNT_W      - starvation counter width, must hold STARVE_MAX

module dmem_port_arbiter #(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned CNT_W      = 3
) (
  input logic                clk,
  input logic                clr,
  dmem_port_arbiter_if.slave bus
);

  // One-hot-style encoding so each read-return output decodes from a single
  // state bit straight out of the register.
  typedef enum logic [1:0] {
    RD_NONE = 2'b00,
    RD_CPU  = 2'b01,
    RD_DEV  = 2'b10
  } rd_state_e;

  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_cnt_q;
  logic [CNT_W-1:0] starve_cnt_d;
  rd_state_e        rd_state_q;
  rd_state_e        rd_state_d;

  logic dev_gnt;
  logic cpu_gnt;
  logic starved;

  // ---------------------------------------------------------------------------
  // Arbitration: purely combinational within the cycle.
  // With STARVE_MAX = 0 the counter never leaves 0, so starved is constantly
  // true and the device wins every contended cycle.
  // ---------------------------------------------------------------------------
  assign starved = (starve_cnt_q == STARVE_LIM);
  assign dev_gnt = bus.dev_req & (~bus.cpu_req | starved);
  assign cpu_gnt = bus.cpu_req & ~dev_gnt;

  assign bus.dev_gnt   = dev_gnt;
  assign bus.cpu_stall = bus.cpu_req & dev_gnt;

  // ---------------------------------------------------------------------------
  // Port mux: idle port drives all zeros so no stray write can reach memory.
  // ---------------------------------------------------------------------------
  assign bus.mem_we    = dev_gnt ? bus.dev_we    : (cpu_gnt ? bus.cpu_we    : 1'b0);
  assign bus.mem_addr  = dev_gnt ? bus.dev_addr  : (cpu_gnt ? bus.cpu_addr  : 32'd0);
  assign bus.mem_wdata = dev_gnt ? bus.dev_wdata : (cpu_gnt ? bus.cpu_wdata : 32'd0);
  assign bus.mem_op    = dev_gnt ? bus.dev_op    : (cpu_gnt ? bus.cpu_op    : 3'd0);

  // ---------------------------------------------------------------------------
  // Starvation counter: counts consecutive denied device-request cycles,
  // saturating at the limit; any grant or dropped request restarts it.
  // ---------------------------------------------------------------------------
  always_comb begin
    starve_cnt_d = '0;
    if (dev_gnt) begin
      starve_cnt_d = '0;
    end else if (bus.dev_req) begin
      if (starve_cnt_q < STARVE_LIM) begin
        starve_cnt_d = starve_cnt_q + CNT_W'(1);
      end else begin
        starve_cnt_d = starve_cnt_q;
      end
    end else begin
      starve_cnt_d = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Read-return tracking: remembers which side owns the data memory returns
  // next cycle. Grants are mutually exclusive, so at most one branch fires.
  // Writes finish in their grant cycle and leave the FSM in RD_NONE.
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_state_d = RD_NONE;
    if (cpu_gnt && !bus.cpu_we) begin
      rd_state_d = RD_CPU;
    end else if (dev_gnt && !bus.dev_we) begin
      rd_state_d = RD_DEV;
    end
  end

  // Async reset discards any in-flight return immediately and hands the CPU
  // priority in the next contention by zeroing the counter.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      starve_cnt_q <= '0;
      rd_state_q   <= RD_NONE;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      rd_state_q   <= rd_state_d;
    end
  end

  // Return data is only exposed to the side that issued the read; otherwise
  // the outputs are held at zero so neither consumer sees stale memory data.
  assign bus.dev_rvalid = rd_state_q[1];
  assign bus.dev_rdata  = rd_state_q[1] ? bus.mem_rdata : 32'd0;
  assign bus.cpu_rdata  = rd_state_q[0] ? bus.mem_rdata : 32'd0;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb/tb_dmem_port_arbiter.sv - scoreboard bench for dmem_port_arbiter

module tb_dmem_port_arbiter;

  localparam int SM = 4;

  logic clk = 1'b0;
  logic clr;

  always #5 clk = ~clk;

  dmem_port_arbiter_if bus();

  dmem_port_arbiter #(
    .STARVE_MAX(SM),
    .CNT_W     (3)
  ) dut (
    .clk(clk),
    .clr(clr),
    .bus(bus)
  );

  typedef struct {
    logic        dev_gnt;
    logic        cpu_stall;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_op;
    logic        dev_rvalid;
    logic [31:0] dev_rdata;
    logic [31:0] cpu_rdata;
  } exp_t;

  exp_t sbq[$];

  int n_vec = 0;
  int n_bad = 0;

  logic [31:0] rmem[logic [31:0]];
  logic [31:0] mmem[logic [31:0]];

  int          denied;
  int          pend_kind;
  logic [31:0] pend_data;

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0F1E_2D3C;
  endfunction

  function logic [31:0] rmem_rd(input logic [31:0] a);
    return rmem.exists(a) ? rmem[a] : dflt(a);
  endfunction

  function logic [31:0] mmem_rd(input logic [31:0] a);
    return mmem.exists(a) ? mmem[a] : dflt(a);
  endfunction

  // Memory responder: synchronous RAM, data valid the cycle after the address.
  always @(posedge clk) begin
    if (bus.mem_we) begin
      rmem[bus.mem_addr] = bus.mem_wdata;
      bus.mem_rdata = $urandom;
    end else begin
      bus.mem_rdata = rmem_rd(bus.mem_addr);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: one expected entry per cycle, compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("dev_gnt",    32'(bus.dev_gnt),    32'(e.dev_gnt));
        chk("cpu_stall",  32'(bus.cpu_stall),  32'(e.cpu_stall));
        chk("mem_we",     32'(bus.mem_we),     32'(e.mem_we));
        chk("mem_addr",   bus.mem_addr,        e.mem_addr);
        chk("mem_wdata",  bus.mem_wdata,       e.mem_wdata);
        chk("mem_op",     32'(bus.mem_op),     32'(e.mem_op));
        chk("dev_rvalid", 32'(bus.dev_rvalid), 32'(e.dev_rvalid));
        chk("dev_rdata",  bus.dev_rdata,       e.dev_rdata);
        chk("cpu_rdata",  bus.cpu_rdata,       e.cpu_rdata);
      end
    end
  end

  // One cycle of stimulus plus the reference model's prediction for it.
  task automatic step(input bit creq, input bit cwe, input logic [31:0] caddr,
                      input logic [31:0] cwd, input logic [2:0] cop,
                      input bit dreq, input bit dwe, input logic [31:0] daddr,
                      input logic [31:0] dwd, input logic [2:0] dop,
                      input bit rst, output bit dgnt);
    exp_t e;
    bit   dwin;
    bit   cwin;
    @(posedge clk);
    #1;
    bus.cpu_req = creq; bus.cpu_we = cwe; bus.cpu_addr = caddr;
    bus.cpu_wdata = cwd; bus.cpu_op = cop;
    bus.dev_req = dreq; bus.dev_we = dwe; bus.dev_addr = daddr;
    bus.dev_wdata = dwd; bus.dev_op = dop;
    clr = ~rst;

    if (rst) begin
      denied = 0;
      pend_kind = 0;
    end
    e.dev_rvalid = (pend_kind == 2);
    e.dev_rdata  = (pend_kind == 2) ? pend_data : 32'd0;
    e.cpu_rdata  = (pend_kind == 1) ? pend_data : 32'd0;

    // Device wins when the CPU is idle or it has waited SM denied cycles.
    dwin = dreq && (!creq || denied >= SM);
    cwin = creq && !dwin;
    e.dev_gnt   = dwin;
    e.cpu_stall = creq && dwin;
    if (dwin) begin
      e.mem_we = dwe; e.mem_addr = daddr; e.mem_wdata = dwd; e.mem_op = dop;
    end else if (cwin) begin
      e.mem_we = cwe; e.mem_addr = caddr; e.mem_wdata = cwd; e.mem_op = cop;
    end else begin
      e.mem_we = 1'b0; e.mem_addr = 32'd0; e.mem_wdata = 32'd0; e.mem_op = 3'd0;
    end

    pend_kind = 0;
    if (cwin && !cwe) begin
      pend_kind = 1; pend_data = mmem_rd(caddr);
    end else if (dwin && !dwe) begin
      pend_kind = 2; pend_data = mmem_rd(daddr);
    end
    if (e.mem_we) mmem[e.mem_addr] = e.mem_wdata;

    if (dwin)       denied = 0;
    else if (dreq)  denied = (denied + 1 > SM) ? SM : denied + 1;
    else            denied = 0;

    if (rst) begin
      denied = 0;
      pend_kind = 0;
    end
    sbq.push_back(e);
    dgnt = dwin;
  endtask

  task automatic idle(input bit rst);
    bit g;
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, rst, g);
  endtask

  task automatic contend(input logic [31:0] ca, input logic [31:0] da, output bit g);
    step(1, 0, ca, 0, 3'd2, 1, 0, da, 0, 3'd2, 0, g);
  endtask

  initial begin
    bit          g;
    bit          dhold;
    bit          creq, cwe, dreq, dwe;
    logic [31:0] ca, cw, da, dw;
    logic [2:0]  co, dop;

    clr = 1'b0;
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0; bus.cpu_op = 0;
    bus.dev_req = 0; bus.dev_we = 0; bus.dev_addr = 0; bus.dev_wdata = 0; bus.dev_op = 0;
    bus.mem_rdata = 0;
    rmem[32'h100] = 32'hDEAD_BEEF;
    mmem[32'h100] = 32'hDEAD_BEEF;
    denied = 0;
    pend_kind = 0;
    pend_data = 0;

    repeat (3) idle(1);
    idle(0);

    // Uncontended CPU read of 0x100.
    step(1, 0, 32'h100, 0, 3'd2, 0, 0, 0, 0, 0, 0, g);
    idle(0);

    // Uncontended device write.
    step(0, 0, 0, 0, 0, 1, 1, 32'h200, 32'h55, 3'd2, 0, g);
    idle(0);

    // Continuous contention: forced device slot every SM+1 cycles.
    for (int i = 0; i < 3 * (SM + 1) + 2; i++) contend(32'h104, 32'h108, g);
    idle(0);

    // Back-to-back device reads.
    step(0, 0, 0, 0, 0, 1, 0, 32'h10, 0, 3'd2, 0, g);
    step(0, 0, 0, 0, 0, 1, 0, 32'h14, 0, 3'd2, 0, g);
    step(0, 0, 0, 0, 0, 1, 0, 32'h18, 0, 3'd2, 0, g);
    idle(0);

    // Device drops request: counter restarts, forced only after SM more.
    contend(32'h104, 32'h10C, g);
    contend(32'h104, 32'h10C, g);
    step(1, 0, 32'h104, 0, 3'd2, 0, 0, 0, 0, 0, 0, g);
    for (int i = 0; i < SM + 1; i++) contend(32'h104, 32'h10C, g);
    idle(0);

    // Reset asserted the cycle after a device read grant.
    step(0, 0, 0, 0, 0, 1, 0, 32'h40, 0, 3'd2, 0, g);
    idle(1);
    idle(0);
    idle(0);
    contend(32'h104, 32'h10C, g);
    idle(0);

    // Randomized traffic; device fields held until granted.
    dhold = 0;
    dreq = 0; dwe = 0; da = 0; dw = 0; dop = 0;
    for (int i = 0; i < 600; i++) begin
      creq = ($urandom_range(0, 9) < 7);
      cwe  = $urandom_range(0, 1);
      ca   = 32'h100 + (32'($urandom_range(0, 15)) << 2);
      cw   = $urandom;
      co   = 3'($urandom_range(0, 7));
      if (!dhold) begin
        dreq = ($urandom_range(0, 9) < 5);
        dwe  = $urandom_range(0, 1);
        da   = 32'h100 + (32'($urandom_range(0, 15)) << 2);
        dw   = $urandom;
        dop  = 3'($urandom_range(0, 7));
      end
      step(creq, cwe, ca, cw, co, dreq, dwe, da, dw, dop, 0, g);
      dhold = dreq && !g;
    end

    idle(0);
    idle(0);
    repeat (2) @(negedge clk);
    #1;
    chk("sb_drain", 32'(sbq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
